// File: rtl/alu_core_pkg.sv
// rtl/alu_core_pkg.sv - shared types and constants for the registered signed ALU
//
// Holds the default operand width, the set-select encoding formed by
// {a_en, b_en}, and the opcode tables for operation sets A, B1 and B2.
package alu_core_pkg;

    localparam int ALU_WIDTH = 5;

    // {a_en, b_en}
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_B1   = 2'b01,
        SEL_A    = 2'b10,
        SEL_B2   = 2'b11
    } set_sel_e;

    typedef enum logic [2:0] {
        A_ADD     = 3'd0,
        A_SUB     = 3'd1,
        A_XOR     = 3'd2,
        A_AND     = 3'd3,
        A_AND_ALT = 3'd4,
        A_OR      = 3'd5,
        A_XNOR    = 3'd6,
        A_ILLEGAL = 3'd7
    } op_a_e;

    typedef enum logic [1:0] {
        B1_NAND    = 2'd0,
        B1_ADD     = 2'd1,
        B1_ADD_ALT = 2'd2,
        B1_ILLEGAL = 2'd3
    } op_b1_e;

    typedef enum logic [1:0] {
        B2_XOR    = 2'd0,
        B2_XNOR   = 2'd1,
        B2_DEC_A  = 2'd2,
        B2_INC2_B = 2'd3
    } op_b2_e;

endpackage

// File: rtl/alu_core_decode.sv
// rtl/alu_core_decode.sv - combinational opcode decode and compute for alu_core
//
// Ports:
//   a_en, b_en : operation-set select
//   a_op       : opcode for set A
//   b_op       : opcode for sets B1 and B2
//   A, B       : signed WIDTH-bit operands
//   result     : signed WIDTH+1-bit result (0 on illegal operation)
//   err        : illegal-operation indication
module alu_core_decode
    import alu_core_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                    a_en,
    input  logic                    b_en,
    input  logic [2:0]              a_op,
    input  logic [1:0]              b_op,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH:0]   result,
    output logic                    err
);

    // Every operation, including the bitwise ones, works on the sign-extended
    // values, so the extra MSB of a logic result is the op applied to the signs.
    logic signed [WIDTH:0] ax;
    logic signed [WIDTH:0] bx;

    assign ax = {A[WIDTH-1], A};
    assign bx = {B[WIDTH-1], B};

    always_comb begin
        // Illegal by default; each legal decode clears err.
        result = '0;
        err    = 1'b1;
        case ({a_en, b_en})
            SEL_A: begin
                err = 1'b0;
                case (a_op)
                    A_ADD:     result = ax + bx;
                    A_SUB:     result = ax - bx;
                    A_XOR:     result = ax ^ bx;
                    A_AND:     result = ax & bx;
                    A_AND_ALT: result = ax & bx;
                    A_OR:      result = ax | bx;
                    A_XNOR:    result = ~(ax ^ bx);
                    default: begin
                        result = '0;
                        err    = 1'b1;
                    end
                endcase
            end
            SEL_B1: begin
                err = 1'b0;
                case (b_op)
                    B1_NAND:    result = ~(ax & bx);
                    B1_ADD:     result = ax + bx;
                    B1_ADD_ALT: result = ax + bx;
                    default: begin
                        result = '0;
                        err    = 1'b1;
                    end
                endcase
            end
            SEL_B2: begin
                err = 1'b0;
                case (b_op)
                    B2_XOR:    result = ax ^ bx;
                    B2_XNOR:   result = ~(ax ^ bx);
                    B2_DEC_A:  result = ax - (WIDTH+1)'(1);
                    default:   result = bx + (WIDTH+1)'(2);
                endcase
            end
            default: begin
                result = '0;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered parameterised signed ALU with enable-selected operation sets
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears C and error_flag
//   ALU_en     : global enable; outputs hold while low
//   a_en, b_en : operation-set select (A, B1, B2)
//   a_op, b_op : opcodes for the selected set
//   A, B       : signed WIDTH-bit operands
//   C          : signed WIDTH+1-bit registered result, one cycle after sampling
//   error_flag : registered illegal-operation flag
module alu_core
    import alu_core_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ALU_en,
    input  logic                    a_en,
    input  logic                    b_en,
    input  logic [2:0]              a_op,
    input  logic [1:0]              b_op,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH:0]   C,
    output logic                    error_flag
);

    logic signed [WIDTH:0] next_C;
    logic                  next_err;

    alu_core_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .a_en   (a_en),
        .b_en   (b_en),
        .a_op   (a_op),
        .b_op   (b_op),
        .A      (A),
        .B      (B),
        .result (next_C),
        .err    (next_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C          <= '0;
            error_flag <= 1'b0;
        end else if (ALU_en) begin
            C          <= next_C;
            error_flag <= next_err;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking scoreboard bench for alu_core
module tb_alu_core;

    localparam int W = 5;

    typedef struct {
        int c;
        int e;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ALU_en;
    logic                a_en;
    logic                b_en;
    logic [2:0]          a_op;
    logic [1:0]          b_op;
    logic signed [W-1:0] A;
    logic signed [W-1:0] B;
    logic signed [W:0]   C;
    logic                error_flag;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_c   = 0;
    int   last_e   = 0;
    exp_t sb[$];

    alu_core #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALU_en     (ALU_en),
        .a_en       (a_en),
        .b_en       (b_en),
        .a_op       (a_op),
        .b_op       (b_op),
        .A          (A),
        .B          (B),
        .C          (C),
        .error_flag (error_flag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input int en, input int ae, input int be,
                         input int aop, input int bop, input int av, input int bv);
        @(negedge clk);
        ALU_en = 1'(en);
        a_en   = 1'(ae);
        b_en   = 1'(be);
        a_op   = 3'(aop);
        b_op   = 2'(bop);
        A      = 5'(av);
        B      = 5'(bv);
    endtask

    task automatic push(input int c, input int e);
        exp_t x;
        x.c = c;
        x.e = e;
        sb.push_back(x);
        last_c = c;
        last_e = e;
    endtask

    task automatic collect(input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check_val({tag, ".C"}, int'(C), x.c);
            check_val({tag, ".err"}, int'(error_flag), x.e);
        end else begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", tag);
        end
    endtask

    task automatic op(input string tag, input int en, input int ae, input int be,
                      input int aop, input int bop, input int av, input int bv,
                      input int c, input int e);
        drive(en, ae, be, aop, bop, av, bv);
        push(c, e);
        collect(tag);
    endtask

    // Reference model on plain integers; operands arrive already in the
    // signed 5-bit range, so int bitwise ops equal the sign-extended ones.
    function automatic void model(input int ae, input int be, input int aop, input int bop,
                                  input int av, input int bv, output int c, output int e);
        c = 0;
        e = 1;
        if (ae == 1 && be == 0) begin
            e = 0;
            case (aop)
                0: c = av + bv;
                1: c = av - bv;
                2: c = av ^ bv;
                3, 4: c = av & bv;
                5: c = av | bv;
                6: c = ~(av ^ bv);
                default: e = 1;
            endcase
        end else if (ae == 0 && be == 1) begin
            e = 0;
            case (bop)
                0: c = ~(av & bv);
                1, 2: c = av + bv;
                default: e = 1;
            endcase
        end else if (ae == 1 && be == 1) begin
            e = 0;
            case (bop)
                0: c = av ^ bv;
                1: c = ~(av ^ bv);
                2: c = av - 1;
                default: c = bv + 2;
            endcase
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sel, aop, bop, av, bv, ec, ee;

        rst_n  = 1'b0;
        ALU_en = 1'b0;
        a_en   = 1'b0;
        b_en   = 1'b0;
        a_op   = '0;
        b_op   = '0;
        A      = '0;
        B      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.C", int'(C), 0);
        check_val("reset.err", int'(error_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-operation, away from any clock edge
        op("pre_rst", 1, 1, 0, 0, 0, 7, 3, 10, 0);
        drive(1, 1, 0, 0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst.C", int'(C), 0);
        check_val("async_rst.err", int'(error_flag), 0);
        @(posedge clk);
        #1;
        check_val("rst_held.C", int'(C), 0);
        check_val("rst_held.err", int'(error_flag), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_c = 0;
        last_e = 0;

        // Set A arithmetic extremes
        op("a_add",     1, 1, 0, 0, 0, 7,   3,  10,  0);
        op("a_add_min", 1, 1, 0, 0, 0, -16, -16, -32, 0);
        op("a_sub_min", 1, 1, 0, 1, 0, -16, 15, -31, 0);
        // Set A logic, illegal, recovery
        op("a_or",      1, 1, 0, 5, 0, 10, 6, 14, 0);
        op("a_illegal", 1, 1, 0, 7, 0, 10, 6, 0,  1);
        op("a_and",     1, 1, 0, 3, 0, 10, 6, 2,  0);
        // Set B1
        op("b1_nand",   1, 0, 1, 0, 0, 10, 6,  -3, 0);
        op("b1_add",    1, 0, 1, 0, 2, -1, -1, -2, 0);
        op("b1_illegal",1, 0, 1, 0, 3, 3,  4,  0,  1);
        // Set B2
        op("b2_dec_a",  1, 1, 1, 0, 2, -16, 0,  -17, 0);
        op("b2_inc_b",  1, 1, 1, 0, 3, 0,   15, 17,  0);
        op("b2_xnor",   1, 1, 1, 0, 1, 0,   0,  -1,  0);
        // Enable off: outputs hold while inputs change
        op("hold0", 0, 1, 0, 0, 0, 5,  5, last_c, last_e);
        op("hold1", 0, 0, 0, 7, 3, -9, 4, last_c, last_e);
        op("hold2", 0, 1, 1, 2, 2, 11, -3, last_c, last_e);
        // No set selected
        op("no_set", 1, 0, 0, 0, 0, 5, 5, 0, 1);

        // Back-to-back random legal ops
        for (int i = 0; i < 100; i++) begin
            sel = int'($urandom_range(0, 2));
            aop = int'($urandom_range(0, 6));
            bop = (sel == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
            av  = int'($urandom_range(0, 31)) - 16;
            bv  = int'($urandom_range(0, 31)) - 16;
            case (sel)
                0:       model(1, 0, aop, bop, av, bv, ec, ee);
                1:       model(0, 1, aop, bop, av, bv, ec, ee);
                default: model(1, 1, aop, bop, av, bv, ec, ee);
            endcase
            case (sel)
                0:       op("rnd_a",  1, 1, 0, aop, bop, av, bv, ec, ee);
                1:       op("rnd_b1", 1, 0, 1, aop, bop, av, bv, ec, ee);
                default: op("rnd_b2", 1, 1, 1, aop, bop, av, bv, ec, ee);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
